// File: rtl/link_pkg.sv
// Shared types and constants for the link read responder.
package link_pkg;

  typedef enum logic [1:0] {IDLE, RD, DRAIN} link_rsp_st_e;

  localparam logic [7:0] POISON_BYTE = 8'hDE;

  // Number of byte-offset bits below the word address for a given beat width.
  function automatic int byte_off_w(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 0;
  endfunction

endpackage

// File: rtl/link_rsp_rtn_pipe.sv
// Registered return stage: aligns the beat tag with memory data and drives the beat outputs.
// LINK_RSP_RANGE_CHK_EN adds the per-beat error flag and poison data substitution.
module link_rsp_rtn_pipe
  import link_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic [2:0]        cnt,
`ifdef LINK_RSP_RANGE_CHK_EN
  input  logic              bad,
`endif
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dvld,
  output logic [2:0]        dcnt,
  output logic [DATA_W-1:0] rdata
`ifdef LINK_RSP_RANGE_CHK_EN
  ,
  output logic              err
`endif
);

`ifdef LINK_RSP_RANGE_CHK_EN
  localparam logic [DATA_W-1:0] POISON = {(DATA_W / 8){POISON_BYTE}};
  logic bad_d1_d, bad_d1_q, err_d, err_q;
`endif

  logic              rd_d1_d, rd_d1_q;
  logic [2:0]        cnt_d1_d, cnt_d1_q;
  logic              dvld_d, dvld_q;
  logic [2:0]        dcnt_d, dcnt_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_comb begin
    rd_d1_d  = rd;
    cnt_d1_d = rd ? cnt : 3'd0;
    // Memory data is valid the cycle after the read, alongside rd_d1.
    dvld_d   = rd_d1_q;
    dcnt_d   = rd_d1_q ? cnt_d1_q : 3'd0;
    rdata_d  = rd_d1_q ? mem_rdata : '0;
`ifdef LINK_RSP_RANGE_CHK_EN
    bad_d1_d = rd & bad;
    err_d    = rd_d1_q & bad_d1_q;
    if (rd_d1_q && bad_d1_q) rdata_d = POISON;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_d1_q  <= 1'b0;
      cnt_d1_q <= 3'd0;
      dvld_q   <= 1'b0;
      dcnt_q   <= 3'd0;
      rdata_q  <= '0;
`ifdef LINK_RSP_RANGE_CHK_EN
      bad_d1_q <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      rd_d1_q  <= rd_d1_d;
      cnt_d1_q <= cnt_d1_d;
      dvld_q   <= dvld_d;
      dcnt_q   <= dcnt_d;
      rdata_q  <= rdata_d;
`ifdef LINK_RSP_RANGE_CHK_EN
      bad_d1_q <= bad_d1_d;
      err_q    <= err_d;
`endif
    end
  end

  assign dvld  = dvld_q;
  assign dcnt  = dcnt_q;
  assign rdata = rdata_q;
`ifdef LINK_RSP_RANGE_CHK_EN
  assign err   = err_q;
`endif

endmodule

// File: rtl/link_rd_responder.sv
// Link req/ack read responder: one request at a time, BURST_LEN-beat burst from a 1-cycle memory.
// Optional address window check under LINK_RSP_RANGE_CHK_EN (poisoned beats, rsp_err).
module link_rd_responder
  import link_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                BURST_LEN = 8,
  parameter int                MEM_AW    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(32'h1000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ack,
  output logic              dvld,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        dcnt,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef LINK_RSP_RANGE_CHK_EN
  ,
  output logic              rsp_err
`endif
);

  localparam int OFF_W = byte_off_w(DATA_W);

  link_rsp_st_e      state_d, state_q;
  logic              ack_d, ack_q;
  logic              rd_d, rd_q;
  logic              mem_rd_d, mem_rd_q;
  logic [2:0]        beat_d, beat_q;
  logic [MEM_AW-1:0] mem_addr_d, mem_addr_q;
  logic              drain_d, drain_q;
  logic              bad_d, bad_q;
  logic              range_bad;

`ifdef LINK_RSP_RANGE_CHK_EN
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, WIN_BYTES};
  localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(BURST_LEN * (DATA_W / 8));
  logic [ADDR_W:0] end_a;

  // One extra bit keeps the burst end from wrapping past the top of the address space.
  always_comb begin
    end_a     = {1'b0, addr} + SPAN;
    range_bad = ({1'b0, addr} < {1'b0, BASE_ADDR}) || (end_a > LIMIT);
  end
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign range_bad   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    rd_d       = rd_q;
    beat_d     = beat_q;
    mem_addr_d = mem_addr_q;
    drain_d    = drain_q;
    bad_d      = bad_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = RD;
          ack_d      = 1'b1;
          rd_d       = 1'b1;
          beat_d     = 3'd0;
          mem_addr_d = addr[MEM_AW+OFF_W-1:OFF_W];
          bad_d      = range_bad;
        end
      end
      RD: begin
        if (beat_q == 3'(BURST_LEN - 1)) begin
          state_d    = DRAIN;
          rd_d       = 1'b0;
          beat_d     = 3'd0;
          mem_addr_d = '0;
          drain_d    = 1'b0;
        end else begin
          beat_d     = beat_q + 3'd1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = IDLE;
          drain_d = 1'b0;
          bad_d   = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A rejected burst still walks the beats but never touches memory.
    mem_rd_d = rd_d & ~bad_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      rd_q       <= 1'b0;
      mem_rd_q   <= 1'b0;
      beat_q     <= 3'd0;
      mem_addr_q <= '0;
      drain_q    <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rd_q       <= rd_d;
      mem_rd_q   <= mem_rd_d;
      beat_q     <= beat_d;
      mem_addr_q <= mem_addr_d;
      drain_q    <= drain_d;
      bad_q      <= bad_d;
    end
  end

  assign ack      = ack_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

  link_rsp_rtn_pipe #(
    .DATA_W(DATA_W)
  ) u_rtn (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd_q),
    .cnt      (beat_q),
`ifdef LINK_RSP_RANGE_CHK_EN
    .bad      (bad_q),
`endif
    .mem_rdata(mem_rdata),
    .dvld     (dvld),
    .dcnt     (dcnt),
    .rdata    (rdata)
`ifdef LINK_RSP_RANGE_CHK_EN
    ,
    .err      (rsp_err)
`endif
  );

endmodule
